// File: rtl/os_fault_seq_ctrl_pkg.sv
// os_ctrl_pkg: state encoding and index helpers shared by
// the output-stationary fault sequencer and its skew generator.
package os_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE,
      FEED,
      DRAIN,
      DONE
   } os_state_e;

   function automatic int idx_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   function automatic int pe_idx(
      input int r,
      input int c,
      input int cols
   );
      return r * cols + c;
   endfunction

endpackage

// File: rtl/os_fault_seq_ctrl_skew.sv
// os_skew_gen: diagonal operand-valid skew for the PE array,
// row r / column c valid for k_len cycles starting at cycle r / c.
module os_skew_gen
   import os_ctrl_pkg::*;
#(
   parameter int ROWS  = 4,
   parameter int COLS  = 4,
   parameter int K_W   = 16,
   parameter int CYC_W = 16
) (
   input  logic             feed,
   input  logic [CYC_W-1:0] cyc,
   input  logic [K_W-1:0]   k_len,
   output logic [ROWS-1:0]  row_valid,
   output logic [COLS-1:0]  col_valid
);

   localparam int W = ((K_W > CYC_W) ? K_W : CYC_W) + 2;

   logic [W-1:0] cyc_x;
   logic [W-1:0] k_x;

   assign cyc_x = W'(cyc);
   assign k_x   = W'(k_len);

   always_comb begin
      row_valid = '0;
      col_valid = '0;
      for (int r = 0; r < ROWS; r++) begin
         row_valid[r] = feed
                      && (cyc_x >= W'(r))
                      && (cyc_x < W'(r) + k_x);
      end
      for (int c = 0; c < COLS; c++) begin
         col_valid[c] = feed
                      && (cyc_x >= W'(c))
                      && (cyc_x < W'(c) + k_x);
      end
   end

endmodule

// File: rtl/os_fault_seq_ctrl.sv
// os_fault_seq_ctrl: tile-pass sequencer with single-PE fault window.
// Optional FAULT_PERMANENT_EN adds a fault_perm (window to pass end).
module os_fault_seq_ctrl
   import os_ctrl_pkg::*;
#(
   parameter int D_W   = 8,
   parameter int ROWS  = 4,
   parameter int COLS  = 4,
   parameter int K_W   = 16,
   parameter int CYC_W = 16,
   localparam int RW   = idx_w(ROWS),
   localparam int CW   = idx_w(COLS)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [K_W-1:0]           k_len,
   input  logic                     fault_en,
   input  logic [RW-1:0]            fault_row,
   input  logic [CW-1:0]            fault_col,
   input  logic [D_W-1:0]           fault_val,
   input  logic [CYC_W-1:0]         fault_start,
   input  logic [CYC_W-1:0]         fault_dur,
`ifdef FAULT_PERMANENT_EN
   input  logic                     fault_perm,
`endif
   output logic                     init_o,
   output logic [ROWS-1:0]          row_valid,
   output logic [COLS-1:0]          col_valid,
   output logic                     drain_en,
   output logic [ROWS*COLS*D_W-1:0] fault_mask,
   output logic [CYC_W-1:0]         cyc,
   output logic                     busy,
   output logic                     done,
   output logic                     cfg_err
);

   localparam int LW = ((K_W > CYC_W) ? K_W : CYC_W) + 2;

   os_state_e state_q;
   os_state_e state_d;
   logic [CYC_W-1:0] cyc_d;

   logic [K_W-1:0]   k_q;
   logic             fen_q;
   logic [RW-1:0]    row_q;
   logic [CW-1:0]    col_q;
   logic [D_W-1:0]   val_q;
   logic [CYC_W-1:0] fs_q;
   logic [CYC_W-1:0] fd_q;
   logic             oor_q;
   logic             perm_q;

   logic [LW-1:0] len;
   logic          last_feed;
   logic          last_drain;
   logic          accept;

   assign accept     = (state_q == IDLE) && start;
   assign len        = LW'(k_q) + LW'(ROWS + COLS - 2);
   assign last_feed  = LW'(cyc) == len - LW'(1);
   assign last_drain = LW'(cyc) == len + LW'(COLS - 1);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cyc     <= '0;
         k_q     <= '0;
         fen_q   <= 1'b0;
         row_q   <= '0;
         col_q   <= '0;
         val_q   <= '0;
         fs_q    <= '0;
         fd_q    <= '0;
         oor_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cyc     <= cyc_d;
         if (accept) begin
            k_q   <= k_len;
            fen_q <= fault_en;
            row_q <= fault_row;
            col_q <= fault_col;
            val_q <= fault_val;
            fs_q  <= fault_start;
            fd_q  <= fault_dur;
            oor_q <= (int'(fault_row) >= ROWS)
                  || (int'(fault_col) >= COLS);
         end
      end
   end

`ifdef FAULT_PERMANENT_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         perm_q <= 1'b0;
      end else if (accept) begin
         perm_q <= fault_perm;
      end
   end
`else
   assign perm_q = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      cyc_d   = cyc;
      unique case (state_q)
         IDLE: begin
            cyc_d = '0;
            if (start) begin
               state_d = (k_len == '0) ? DONE : FEED;
            end
         end
         FEED: begin
            cyc_d = cyc + CYC_W'(1);
            if (last_feed) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            cyc_d = cyc + CYC_W'(1);
            if (last_drain) begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
            cyc_d   = '0;
         end
         default: begin
            state_d = IDLE;
            cyc_d   = '0;
         end
      endcase
   end

   // outputs are computed for the next cycle and registered
   logic            feed_d;
   logic [K_W-1:0]  k_sel;
   logic [ROWS-1:0] rv_d;
   logic [COLS-1:0] cv_d;
   logic            init_d;
   logic            drain_d;
   logic            busy_d;
   logic            done_d;
   logic            err_d;

   assign feed_d = (state_d == FEED);
   assign k_sel  = (state_q == IDLE) ? k_len : k_q;

   os_skew_gen #(
      .ROWS  (ROWS),
      .COLS  (COLS),
      .K_W   (K_W),
      .CYC_W (CYC_W)
   ) u_skew (
      .feed      (feed_d),
      .cyc       (cyc_d),
      .k_len     (k_sel),
      .row_valid (rv_d),
      .col_valid (cv_d)
   );

   always_comb begin
      init_d  = feed_d && (cyc_d == '0);
      drain_d = (state_d == DRAIN);
      busy_d  = (state_d != IDLE);
      done_d  = (state_d == DONE);
      err_d   = done_d && (state_q == DRAIN) && oor_q;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         init_o    <= 1'b0;
         row_valid <= '0;
         col_valid <= '0;
         drain_en  <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         cfg_err   <= 1'b0;
      end else begin
         init_o    <= init_d;
         row_valid <= rv_d;
         col_valid <= cv_d;
         drain_en  <= drain_d;
         busy      <= busy_d;
         done      <= done_d;
         cfg_err   <= err_d;
      end
   end

   // window compare is one bit wider so start+dur never wraps
   logic [CYC_W:0] c_x;
   logic [CYC_W:0] fs_x;
   logic [CYC_W:0] fe_x;
   logic           in_win;
   logic           active;

   assign c_x    = {1'b0, cyc};
   assign fs_x   = {1'b0, fs_q};
   assign fe_x   = fs_x + {1'b0, fd_q};
   assign in_win = (c_x >= fs_x) && (perm_q || (c_x < fe_x));
   assign active = fen_q && !oor_q && (fd_q != '0)
                && ((state_q == FEED) || (state_q == DRAIN))
                && in_win;

   for (genvar r = 0; r < ROWS; r++) begin : g_row
      for (genvar c = 0; c < COLS; c++) begin : g_col
         assign fault_mask[pe_idx(r, c, COLS)*D_W +: D_W] =
            (active && (int'(row_q) == r) && (int'(col_q) == c))
            ? val_q : '0;
      end
   end

endmodule

// File: tb/tb_os_fault_seq_ctrl.sv
// tb_os_fault_seq_ctrl: scoreboard bench for the tile-pass sequencer,
// 4x4 and 6x4 instances; exercises FAULT_PERMANENT_EN when defined.
module tb_os_fault_seq_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        start4;
   logic        start6;
   logic [15:0] k_len;
   logic        fault_en;
   logic [1:0]  row4;
   logic [2:0]  row6;
   logic [1:0]  fault_col;
   logic [7:0]  fault_val;
   logic [15:0] fault_start;
   logic [15:0] fault_dur;
`ifdef FAULT_PERMANENT_EN
   logic        fault_perm;
`endif

   logic         init4, drain4, busy4, done4, err4;
   logic [3:0]   rv4, cv4;
   logic [127:0] mask4;
   logic [15:0]  cyc4;

   logic         init6, drain6, busy6, done6, err6;
   logic [5:0]   rv6;
   logic [3:0]   cv6;
   logic [191:0] mask6;
   logic [15:0]  cyc6;

   os_fault_seq_ctrl #(
      .D_W(8), .ROWS(4), .COLS(4), .K_W(16), .CYC_W(16)
   ) dut4 (
      .clk         (clk),
      .rst         (rst),
      .start       (start4),
      .k_len       (k_len),
      .fault_en    (fault_en),
      .fault_row   (row4),
      .fault_col   (fault_col),
      .fault_val   (fault_val),
      .fault_start (fault_start),
      .fault_dur   (fault_dur),
`ifdef FAULT_PERMANENT_EN
      .fault_perm  (fault_perm),
`endif
      .init_o      (init4),
      .row_valid   (rv4),
      .col_valid   (cv4),
      .drain_en    (drain4),
      .fault_mask  (mask4),
      .cyc         (cyc4),
      .busy        (busy4),
      .done        (done4),
      .cfg_err     (err4)
   );

   os_fault_seq_ctrl #(
      .D_W(8), .ROWS(6), .COLS(4), .K_W(16), .CYC_W(16)
   ) dut6 (
      .clk         (clk),
      .rst         (rst),
      .start       (start6),
      .k_len       (k_len),
      .fault_en    (fault_en),
      .fault_row   (row6),
      .fault_col   (fault_col),
      .fault_val   (fault_val),
      .fault_start (fault_start),
      .fault_dur   (fault_dur),
`ifdef FAULT_PERMANENT_EN
      .fault_perm  (fault_perm),
`endif
      .init_o      (init6),
      .row_valid   (rv6),
      .col_valid   (cv6),
      .drain_en    (drain6),
      .fault_mask  (mask6),
      .cyc         (cyc6),
      .busy        (busy6),
      .done        (done6),
      .cfg_err     (err6)
   );

   typedef struct packed {
      logic         init;
      logic [7:0]   rv;
      logic [7:0]   cv;
      logic         drain;
      logic         busy;
      logic         done;
      logic         err;
      logic [15:0]  cyc;
      logic [255:0] mask;
   } obs_t;

   obs_t q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic check(
      input string        tag,
      input logic [255:0] got,
      input logic [255:0] exp
   );
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h exp %0h", tag, got, exp);
      end
   endtask

   function automatic obs_t sample(input int sel);
      obs_t o;
      o = '0;
      if (sel == 0) begin
         o.init = init4; o.rv[3:0] = rv4; o.cv[3:0] = cv4;
         o.drain = drain4; o.busy = busy4; o.done = done4;
         o.err = err4; o.cyc = cyc4; o.mask[127:0] = mask4;
      end else begin
         o.init = init6; o.rv[5:0] = rv6; o.cv[3:0] = cv6;
         o.drain = drain6; o.busy = busy6; o.done = done6;
         o.err = err6; o.cyc = cyc6; o.mask[191:0] = mask6;
      end
      return o;
   endfunction

   task automatic cmp(input string w, input obs_t o, input obs_t e);
      check({w, ".init"},  o.init,  e.init);
      check({w, ".rv"},    o.rv,    e.rv);
      check({w, ".cv"},    o.cv,    e.cv);
      check({w, ".drain"}, o.drain, e.drain);
      check({w, ".busy"},  o.busy,  e.busy);
      check({w, ".done"},  o.done,  e.done);
      check({w, ".err"},   o.err,   e.err);
      check({w, ".cyc"},   o.cyc,   e.cyc);
      check({w, ".mask"},  o.mask,  e.mask);
   endtask

   task automatic push_pass(
      input int R, input int C, input int k, input bit fen,
      input int fr, input int fc, input int fv,
      input int fs, input int fd, input bit perm
   );
      obs_t e;
      int   len;
      bit   oor;
      oor = (fr >= R) || (fc >= C);
      if (k == 0) begin
         e = '0; e.busy = 1'b1; e.done = 1'b1;
         q.push_back(e);
      end else begin
         len = k + R + C - 2;
         for (int t = 0; t < len + C; t++) begin
            e = '0; e.busy = 1'b1; e.cyc = 16'(t);
            if (t < len) begin
               e.init = (t == 0);
               for (int r = 0; r < R; r++)
                  e.rv[r] = (t >= r) && (t < r + k);
               for (int c = 0; c < C; c++)
                  e.cv[c] = (t >= c) && (t < c + k);
            end else begin
               e.drain = 1'b1;
            end
            if (fen && !oor && fd != 0 && t >= fs
                && (perm || t < fs + fd))
               e.mask[(fr*C+fc)*8 +: 8] = 8'(fv);
            q.push_back(e);
         end
         e = '0; e.busy = 1'b1; e.done = 1'b1;
         e.err = oor; e.cyc = 16'(len + C);
         q.push_back(e);
      end
      e = '0;
      q.push_back(e);
   endtask

   task automatic run(
      input string nm, input int sel, input int k, input bit fen,
      input int fr, input int fc, input int fv,
      input int fs, input int fd, input bit perm,
      input int poke, input int rst_at
   );
      obs_t o, e;
      int   i;
      k_len = 16'(k); fault_en = fen;
      row4 = 2'(fr); row6 = 3'(fr); fault_col = 2'(fc);
      fault_val = 8'(fv);
      fault_start = 16'(fs); fault_dur = 16'(fd);
`ifdef FAULT_PERMANENT_EN
      fault_perm = perm;
`endif
      if (sel == 0) start4 = 1'b1;
      else start6 = 1'b1;
      push_pass(sel == 0 ? 4 : 6, 4, k, fen, fr, fc, fv, fs, fd, perm);
      i = 0;
      while (q.size() > 0) begin
         @(posedge clk); #1;
         start4 = (sel == 0) && (i == poke);
         start6 = 1'b0;
         e = q.pop_front();
         o = sample(sel);
         cmp($sformatf("%s[%0d]", nm, i), o, e);
         if (i == rst_at) begin
            #2 rst = 1'b0;
            #1 o = sample(sel);
            e = '0;
            cmp({nm, ".async_rst"}, o, e);
            q.delete();
         end
         i++;
      end
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout exp finish");
      $fatal(1);
   end

   initial begin
      obs_t z;
      z = '0;
      rst = 1'b0; start4 = 1'b0; start6 = 1'b0;
      k_len = '0; fault_en = 1'b0; row4 = '0; row6 = '0;
      fault_col = '0; fault_val = '0;
      fault_start = '0; fault_dur = '0;
`ifdef FAULT_PERMANENT_EN
      fault_perm = 1'b0;
`endif
      repeat (2) @(posedge clk);
      #1;
      cmp("reset4", sample(0), z);
      cmp("reset6", sample(1), z);
      rst = 1'b1;
      @(posedge clk); #1;

      run("basic", 0, 3, 0, 0, 0, 0, 0, 0, 0, -1, -1);
      run("trans", 0, 3, 1, 1, 2, 'h80, 4, 2, 0, -1, -1);
      run("empty", 0, 0, 1, 1, 2, 'h80, 0, 5, 0, -1, -1);
      run("busy", 0, 3, 0, 0, 0, 0, 0, 0, 0, 2, -1);
      run("clip", 0, 5, 1, 3, 0, 'h5a, 0, 100, 0, -1, -1);
      run("nowrap", 0, 3, 1, 0, 0, 'haa, 8, 'hffff, 0, -1, -1);
      run("dur0", 0, 4, 1, 0, 3, 'h01, 6, 0, 0, -1, -1);
      run("late", 0, 3, 1, 3, 3, 'hc3, 'hfffe, 2, 0, -1, -1);
      run("oor", 1, 3, 1, 7, 1, 'hff, 0, 50, 0, -1, -1);
      run("r6ok", 1, 2, 1, 5, 3, 'h11, 3, 4, 0, -1, -1);
      run("midrst", 0, 4, 1, 2, 1, 'h33, 2, 3, 0, -1, 3);
      @(posedge clk); #1;
      cmp("held_rst", sample(0), z);
      rst = 1'b1;
      run("fresh", 0, 2, 1, 2, 1, 'h33, 1, 2, 0, -1, -1);
`ifdef FAULT_PERMANENT_EN
      run("perm", 0, 3, 1, 1, 2, 'h80, 8, 1, 1, -1, -1);
      run("perm0", 0, 3, 1, 1, 2, 'h80, 8, 0, 1, -1, -1);
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
